// File: rtl/univ_shift_reg.sv
// Universal shift register: parallel load, single-step shifts and a multi-step
// shift engine (logical / rotate / arithmetic) with busy/done handshake.
module univ_shift_reg #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned AW    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld,
    input  logic             sr,
    input  logic             sl,
    input  logic [WIDTH-1:0] d_in,
    input  logic [1:0]       mode,
    input  logic             ser_in,
    input  logic             start,
    input  logic             dir,
    input  logic [AW-1:0]    amt,
    output logic [WIDTH-1:0] q,
    output logic             ser_out,
    output logic             busy,
    output logic             done
);

    localparam logic [1:0] MODE_ROT   = 2'b01;
    localparam logic [1:0] MODE_ARITH = 2'b10;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    state_e           state_q;
    logic [AW-1:0]    count_q;
    logic [1:0]       mode_q;
    logic             dir_q;
    logic [WIDTH-1:0] q_q;
    logic             ser_q;
    logic             busy_q;
    logic             done_q;

    logic             step_left_c;
    logic [1:0]       step_mode_c;
    logic [WIDTH-1:0] q_d;
    logic             ser_d;

    // One-step result: latched dir/mode while shifting, live controls when idle (sr beats sl)
    always_comb begin
        step_left_c = (state_q == SHIFT) ? dir_q : ~sr;
        step_mode_c = (state_q == SHIFT) ? mode_q : mode;
        q_d         = q_q;
        ser_d       = ser_q;
        if (step_left_c) begin
            ser_d = q_q[WIDTH-1];
            case (step_mode_c)
                MODE_ROT:   q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
                MODE_ARITH: q_d = {q_q[WIDTH-2:0], 1'b0};
                default:    q_d = {q_q[WIDTH-2:0], ser_in};
            endcase
        end else begin
            ser_d = q_q[0];
            case (step_mode_c)
                MODE_ROT:   q_d = {q_q[0], q_q[WIDTH-1:1]};
                MODE_ARITH: q_d = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
                default:    q_d = {ser_in, q_q[WIDTH-1:1]};
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
            mode_q  <= '0;
            dir_q   <= 1'b0;
            q_q     <= '0;
            ser_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else if (ld) begin
            state_q <= IDLE;
            count_q <= '0;
            q_q     <= d_in;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state_q == SHIFT) begin
                q_q   <= q_d;
                ser_q <= ser_d;
                if (count_q == AW'(1)) begin
                    state_q <= IDLE;
                    count_q <= '0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end else begin
                    count_q <= count_q - AW'(1);
                end
            end else if (start) begin
                // Zero-length request completes immediately with a lone done pulse
                if (amt == '0) begin
                    done_q <= 1'b1;
                end else begin
                    state_q <= SHIFT;
                    count_q <= amt;
                    mode_q  <= mode;
                    dir_q   <= dir;
                    busy_q  <= 1'b1;
                end
            end else if (sr || sl) begin
                q_q   <= q_d;
                ser_q <= ser_d;
            end
        end
    end

    assign q       = q_q;
    assign ser_out = ser_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: doc/univ_shift_reg.md
UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

Interface
REQ-001 Parameter WIDTH, default 8: register width in bits (WIDTH >= 2).
REQ-002 Parameter AW, default 4: width of shift-amount input; 2^AW-1 >= WIDTH.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 ld  input  1  parallel load of d_in.
REQ-006 sr  input  1  single-step right shift (idle only).
REQ-007 sl  input  1  single-step left shift (idle only).
REQ-008 d_in  input  WIDTH  parallel load data.
REQ-009 mode  input  2  00 logical (fill = ser_in), 01 rotate, 10 arithmetic, 11 reserved (behaves as 00).
REQ-010 ser_in  input  1  fill bit for logical shifts.
REQ-011 start  input  1  begin multi-step shift of amt positions.
REQ-012 dir  input  1  direction for start: 0 right, 1 left.
REQ-013 amt  input  AW  number of single-bit steps for start.
REQ-014 q  output  WIDTH  register contents.
REQ-015 ser_out  output  1  last bit shifted out.
REQ-016 busy  output  1  multi-step shift in progress.
REQ-017 done  output  1  one-cycle pulse: multi-step shift complete.

Function
REQ-018 States IDLE and SHIFT; mode, dir and amt sampled only at start acceptance and held internally for the whole operation.
REQ-019 Priority per edge: rst > ld > (SHIFT step) > start > sr > sl > hold.
REQ-020 ld in any state: q <= d_in, state -> IDLE, busy <= 0, done <= 0, internal count cleared (aborts any operation without done).
REQ-021 One step right: logical q <= {fill, q[W-1:1]}; rotate q <= {q[0], q[W-1:1]}; arithmetic q <= {q[W-1], q[W-1:1]}; ser_out <= q[0].
REQ-022 One step left: logical q <= {q[W-2:0], fill}; rotate q <= {q[W-2:0], q[W-1]}; arithmetic q <= {q[W-2:0], 1'b0}; ser_out <= q[W-1].
REQ-023 sr/sl in IDLE without ld/start: one step using current mode; sr wins if both high; no busy/done activity.
REQ-024 start in IDLE with amt != 0: on acceptance edge count <= amt, busy <= 1, q unchanged; state -> SHIFT.
REQ-025 In SHIFT, one step per edge in latched dir/mode; count decrements; the edge performing the final step sets busy <= 0, done <= 1, state -> IDLE.
REQ-026 Latency: busy high exactly amt cycles; done high exactly one cycle, coincident with first cycle busy is low; q final in that cycle.
REQ-027 start in IDLE with amt == 0: q unchanged, busy stays 0, done pulses one cycle after acceptance edge.
REQ-028 start, sr, sl ignored while in SHIFT.
REQ-029 amt > WIDTH permitted: steps still performed one per cycle (logical/arithmetic saturate naturally, rotate wraps modulo WIDTH).
REQ-030 ser_out holds its value on edges with no step.
REQ-031 done deasserts on the edge after its pulse regardless of inputs; start in the done cycle is accepted normally.

Reset
REQ-032 On an edge with rst = 1: q <= 0, ser_out <= 0, busy <= 0, done <= 0, count <= 0, state -> IDLE, including mid-operation; no done is produced for an aborted operation.

Verification (WIDTH=8)
REQ-033 rst 1 cycle, then ld, d_in=8'hA5 -> q=8'hA5, busy=0, done=0.
REQ-034 q=8'hA5, mode=01, dir=0, amt=3, start -> busy high 3 cycles, then q=8'hB4, done one cycle, ser_out=1.
REQ-035 q=8'h96, mode=10, dir=0, amt=2, start -> q=8'hE5 at done; left amt=1 from 8'h81 arithmetic -> q=8'h02.
REQ-036 q=8'h81, mode=00, ser_in=1, sl pulse -> q=8'h03, ser_out=1; sr and sl together from 8'h81 -> right step, q=8'hC0.
REQ-037 amt=0 start -> q unchanged, busy never high, done one cycle later; amt=10 rotate from 8'h01 right -> q=8'h40.
REQ-038 amt=5 start, rst at 2nd busy cycle -> next cycle q=0, busy=0, done never pulses; repeat with ld d_in=8'h3C instead -> q=8'h3C, busy=0, no done.
